// File: rtl/lsu_word_adapter.sv
// Byte-addressed RV32I load/store adapter for a word-only synchronous data memory.
// Sub-word stores are done as read-modify-write; illegal requests never reach memory.
module lsu_word_adapter #(
    parameter int ADDR_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    // state   | meaning
    // IDLE    | waiting for req_i; done_o of the previous op may be high here
    // LD_RD   | load read strobe on the memory bus
    // LD_CAP  | load data valid on mem_rdata_i, captured at the next edge
    // RMW_RD  | sub-word store: read strobe for the old word
    // RMW_MRG | old word valid, merged word driven at the next edge
    // ST_WR   | write strobe on the memory bus
    // RESP    | rejected request, done_o/err_o high
    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_CAP,
        RMW_RD,
        RMW_MRG,
        ST_WR,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;

    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        f3_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [31:0] word_idx;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    assign word_idx     = 32'(addr_i[ADDR_W+1:2]);
    assign out_of_range = (addr_i >> (ADDR_W + 2)) != 32'd0;

    always_comb begin
        f3_ok = 1'b0;
        if (we_i) begin
            f3_ok = funct3_i inside {3'd0, 3'd1, 3'd2};
        end else begin
            f3_ok = funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        end
    end

    // funct3[1:0] gives the access size for every legal encoding
    always_comb begin
        misaligned = 1'b0;
        case (funct3_i[1:0])
            2'd1:    misaligned = addr_i[0];
            2'd2:    misaligned = addr_i[1:0] != 2'd0;
            default: misaligned = 1'b0;
        endcase
    end

    assign req_err = !f3_ok || misaligned || out_of_range;

    always_comb begin
        byte_sel = mem_rdata_i[7:0];
        case (off_q)
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
    end

    assign half_sel = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        load_val = mem_rdata_i;
        case (funct3_q)
            3'd0:    load_val = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_val = {24'd0, byte_sel};
            3'd5:    load_val = {16'd0, half_sel};
            default: load_val = mem_rdata_i;
        endcase
    end

    always_comb begin
        merge_val = mem_rdata_i;
        if (funct3_q[1:0] == 2'd0) begin
            case (off_q)
                2'd0:    merge_val[7:0]   = wdata_q[7:0];
                2'd1:    merge_val[15:8]  = wdata_q[7:0];
                2'd2:    merge_val[23:16] = wdata_q[7:0];
                default: merge_val[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merge_val[31:16] = wdata_q;
        end else begin
            merge_val[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    funct3_d = funct3_i;
                    off_d    = addr_i[1:0];
                    wdata_d  = wdata_i[15:0];
                    if (req_err) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        mem_addr_d = word_idx;
                        if (!we_i) begin
                            state_d  = LD_RD;
                            mem_rd_d = 1'b1;
                        end else if (funct3_i == 3'd2) begin
                            state_d     = ST_WR;
                            mem_wr_d    = 1'b1;
                            mem_wdata_d = wdata_i;
                        end else begin
                            state_d  = RMW_RD;
                            mem_rd_d = 1'b1;
                        end
                    end
                end
            end
            LD_RD:   state_d = LD_CAP;
            LD_CAP: begin
                rdata_d = load_val;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            RMW_RD:  state_d = RMW_MRG;
            RMW_MRG: begin
                mem_wdata_d = merge_val;
                mem_wr_d    = 1'b1;
                state_d     = ST_WR;
            end
            ST_WR: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            wdata_q     <= 16'd0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign busy_o      = state_q != IDLE;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
